// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the configuration register file port arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, request-to-ack latency constants, default implemented row count.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // Cycles from a request sampled in IDLE to its ack pulse.
  localparam int WR_LATENCY        = 2;
  localparam int RD_LATENCY        = 3;
  localparam int RANGE_ERR_LATENCY = 1;

  localparam int NUM_MEM_ROWS_DEFAULT = 10;

endpackage

// File: rtl/rr_arb2.sv
// Purpose : two-input round-robin grant with a one-bit preference pointer.
// Latency : grant is combinational from req; pointer updates on the clock after advance.
// Backpressure: none; a requester simply keeps req high until it is granted.
// Ports   : clock, reset_sn (async active-low), req[1:0], advance (a grant was taken this cycle),
//           gnt[1:0] one-hot (or zero when nobody requests).
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_sn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr_q = 0 prefers r0, 1 prefers r1.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    // After a grant, prefer whichever requester did not win.
    if (advance && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clock or negedge reset_sn) begin
    if (!reset_sn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Purpose : shares the single-port config register file between r0 (host bridge) and r1 (sequencer).
// Latency : req sampled in IDLE -> ack after 2 cycles (write) or 3 cycles (read); 1 cycle on range error.
// Backpressure: one transaction at a time; a requester holds req and its fields stable until its ack.
// Ports   : clock, reset_sn (async active-low); per requester rN_req/we/addr/wdata in, rN_ack/rdata/err out;
//           busy; register file side memory_enable_n/write_n/read_n (active low), memory_address,
//           memory_data_in (write data), memory_data_out (registered read data, valid after read strobe).
// Option  : define MEM_ARB_RANGE_CHECK_EN to reject addresses >= NUM_MEM_ROWS with rN_err instead of
//           forwarding them; without it rN_err is always 0.
import mem_arb_pkg::*;

module memory_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int NUM_MEM_ROWS = NUM_MEM_ROWS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_sn,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              busy,
  output logic              memory_enable_n,
  output logic              memory_write_n,
  output logic              memory_read_n,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_data_in,
  input  logic [DATA_W-1:0] memory_data_out
);

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHK_EN = 1'b1;
`else
  localparam bit RANGE_CHK_EN = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic              win_q, win_d;      // 0 = r0 owns the current transaction, 1 = r1
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;      // latched out-of-range flag for the current transaction
  logic              en_n_q, en_n_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic              r0_ack_q, r0_ack_d;
  logic              r1_ack_q, r1_ack_d;
  logic              r0_err_q, r0_err_d;
  logic              r1_err_q, r1_err_d;

  logic [1:0]        gnt;
  logic              advance;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;
  logic              cmd_d;
  logic              done_d;

  rr_arb2 u_rr_arb2 (
    .clock    (clock),
    .reset_sn (reset_sn),
    .req      ({r1_req, r0_req}),
    .advance  (advance),
    .gnt      (gnt)
  );

  // Fields of whichever requester the arbiter is granting this cycle.
  always_comb begin
    sel_we    = gnt[1] ? r1_we    : r0_we;
    sel_addr  = gnt[1] ? r1_addr  : r0_addr;
    sel_wdata = gnt[1] ? r1_wdata : r0_wdata;
    sel_oor   = RANGE_CHK_EN && (sel_addr >= ADDR_W'(NUM_MEM_ROWS));
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          advance = 1'b1;
          win_d   = gnt[1];
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          oor_d   = sel_oor;
          // Out-of-range requests skip the register file entirely.
          state_d = sel_oor ? ST_DONE : ST_CMD;
        end
      end
      ST_CMD: begin
        state_d = we_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // Register file output is registered, so read data is valid here.
        if (win_q) begin
          r1_rdata_d = memory_data_out;
        end else begin
          r0_rdata_d = memory_data_out;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes and acks are decoded from the next state so they leave flops.
    cmd_d    = (state_d == ST_CMD);
    done_d   = (state_d == ST_DONE);
    en_n_d   = !cmd_d;
    wr_n_d   = !(cmd_d && we_d);
    rd_n_d   = !(cmd_d && !we_d);
    r0_ack_d = done_d && !win_d;
    r1_ack_d = done_d && win_d;
    r0_err_d = r0_ack_d && oor_d;
    r1_err_d = r1_ack_d && oor_d;
  end

  always_ff @(posedge clock or negedge reset_sn) begin
    if (!reset_sn) begin
      state_q    <= ST_IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      en_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      en_n_q     <= en_n_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      r0_ack_q   <= r0_ack_d;
      r1_ack_q   <= r1_ack_d;
      r0_err_q   <= r0_err_d;
      r1_err_q   <= r1_err_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign memory_enable_n = en_n_q;
  assign memory_write_n  = wr_n_q;
  assign memory_read_n   = rd_n_q;
  assign memory_address  = addr_q;
  assign memory_data_in  = wdata_q;
  assign r0_ack          = r0_ack_q;
  assign r1_ack          = r1_ack_q;
  assign r0_rdata        = r0_rdata_q;
  assign r1_rdata        = r1_rdata_q;
  assign r0_err          = r0_err_q;
  assign r1_err          = r1_err_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Purpose : directed self-checking bench for memory_port_arbiter with a registered-read register file model.
// Latency : checks write/read/range-error ack latency and back-to-back spacing.
// Backpressure: requesters hold req until ack; simultaneous requests exercise round-robin order.
module tb_memory_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset_sn;
  logic              r0_req, r0_we, r1_req, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_ack, r1_ack, r0_err, r1_err;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              busy;
  logic              memory_enable_n, memory_write_n, memory_read_n;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] memory_data_in;
  logic [DATA_W-1:0] memory_data_out;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int en_pulses = 0;
  int r0_ack_cnt = 0;
  logic preload;
  logic [DATA_W-1:0] mem [0:255];

  always #5 clock = ~clock;

  memory_port_arbiter dut (
    .clock           (clock),
    .reset_sn        (reset_sn),
    .r0_req          (r0_req),
    .r0_we           (r0_we),
    .r0_addr         (r0_addr),
    .r0_wdata        (r0_wdata),
    .r0_ack          (r0_ack),
    .r0_rdata        (r0_rdata),
    .r0_err          (r0_err),
    .r1_req          (r1_req),
    .r1_we           (r1_we),
    .r1_addr         (r1_addr),
    .r1_wdata        (r1_wdata),
    .r1_ack          (r1_ack),
    .r1_rdata        (r1_rdata),
    .r1_err          (r1_err),
    .busy            (busy),
    .memory_enable_n (memory_enable_n),
    .memory_write_n  (memory_write_n),
    .memory_read_n   (memory_read_n),
    .memory_address  (memory_address),
    .memory_data_in  (memory_data_in),
    .memory_data_out (memory_data_out)
  );

  // Register file model: registered read data, valid the cycle after the read strobe.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[0] <= 16'h1234;
      memory_data_out <= '0;
    end else if (!memory_enable_n) begin
      if (!memory_write_n) mem[memory_address] <= memory_data_in;
      if (!memory_read_n) memory_data_out <= mem[memory_address];
    end
  end

  // Strobe monitor: counts enable pulses and checks write/read never overlap.
  always @(negedge clock) begin
    if (r0_ack === 1'b1) r0_ack_cnt++;
    if (reset_sn && !memory_enable_n) begin
      en_pulses++;
      checks++;
      assert (!(memory_write_n == 1'b0 && memory_read_n == 1'b0)) else begin
        errs++;
        $error("FAIL strobe_overlap observed write_n=%0b read_n=%0b expected not both 0",
               memory_write_n, memory_read_n);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // who: 0 = r0 ack, 1 = r1 ack, 2 = no ack within maxc cycles.
  task automatic wait_ack(input int maxc, output int who);
    who = 2;
    for (int k = 0; k < maxc; k++) begin
      step();
      if (r0_ack === 1'b1) begin
        who = 0;
        break;
      end
      if (r1_ack === 1'b1) begin
        who = 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int c0;
    int p0;
    int a0;
    int last;

    reset_sn = 1'b0;
    preload  = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'd0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'd0; r1_wdata = '0;

    // Reset held with r0 requesting.
    repeat (3) step();
    check("rst_enable_n", memory_enable_n, 1);
    check("rst_write_n", memory_write_n, 1);
    check("rst_read_n", memory_read_n, 1);
    check("rst_busy", busy, 0);
    check("rst_r0_ack", r0_ack, 0);
    check("rst_r1_ack", r1_ack, 0);
    check("rst_address", memory_address, 0);
    check("rst_r0_rdata", r0_rdata, 0);

    // Release: r0 read of row 0 granted immediately.
    preload  = 1'b0;
    reset_sn = 1'b1;
    step();
    check("rel_cmd_enable_n", memory_enable_n, 0);
    check("rel_cmd_read_n", memory_read_n, 0);
    check("rel_busy", busy, 1);
    step();
    step();
    check("rel_r0_ack", r0_ack, 1);
    check("rel_r0_rdata", r0_rdata, 16'h1234);
    r0_req = 1'b0;
    step();
    check("rel_idle_busy", busy, 0);
    check("rel_idle_ack", r0_ack, 0);

    // r0 write addr 3.
    r0_we = 1'b1; r0_addr = 8'd3; r0_wdata = 16'hA5A5; r0_req = 1'b1;
    p0 = en_pulses;
    step();
    check("wr_cmd_enable_n", memory_enable_n, 0);
    check("wr_cmd_write_n", memory_write_n, 0);
    check("wr_cmd_read_n", memory_read_n, 1);
    check("wr_cmd_address", memory_address, 3);
    check("wr_cmd_data_in", memory_data_in, 16'hA5A5);
    check("wr_cmd_no_ack", r0_ack, 0);
    step();
    check("wr_done_ack", r0_ack, 1);
    check("wr_done_err", r0_err, 0);
    check("wr_done_enable_n", memory_enable_n, 1);
    check("wr_one_pulse", en_pulses - p0, 1);
    r0_req = 1'b0;
    step();

    // r1 reads it back.
    r1_we = 1'b0; r1_addr = 8'd3; r1_req = 1'b1;
    c0 = cyc;
    wait_ack(6, who);
    check("rd_who", who, 1);
    check("rd_latency", cyc - c0, RD_LATENCY);
    check("rd_r1_rdata", r1_rdata, 16'hA5A5);
    check("rd_r0_no_ack", r0_ack, 0);
    r1_req = 1'b0;
    step();

    // Simultaneous requests, two rounds -> r0, r1, r0, r1.
    for (int rnd = 0; rnd < 2; rnd++) begin
      r0_we = 1'b1; r0_addr = 8'd5; r0_wdata = 16'h5000 + 16'(rnd);
      r1_we = 1'b1; r1_addr = 8'd6; r1_wdata = 16'h6000 + 16'(rnd);
      r0_req = 1'b1; r1_req = 1'b1;
      wait_ack(8, who);
      check("arb_first", who, 0);
      r0_req = 1'b0;
      wait_ack(8, who);
      check("arb_second", who, 1);
      r1_req = 1'b0;
      step();
    end
    check("arb_r0_rdata_kept", r0_rdata, 16'h1234);
    check("arb_r1_rdata_kept", r1_rdata, 16'hA5A5);

    // Reset pulsed during WAIT of an r0 read.
    r0_we = 1'b0; r0_addr = 8'd5; r0_req = 1'b1;
    step();
    step();
    check("wait_busy", busy, 1);
    check("wait_read_n", memory_read_n, 1);
    #2 reset_sn = 1'b0;
    #1;
    check("midrst_enable_n", memory_enable_n, 1);
    check("midrst_read_n", memory_read_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ack", r0_ack, 0);
    check("midrst_rdata", r0_rdata, 0);
    r0_req = 1'b0;
    step();
    step();
    reset_sn = 1'b1;
    step();
    check("postrst_r0_ack", r0_ack, 0);
    check("postrst_busy", busy, 0);

    r0_we = 1'b0; r0_addr = 8'd6; r0_req = 1'b1;
    c0 = cyc;
    wait_ack(6, who);
    check("postrst_who", who, 0);
    check("postrst_latency", cyc - c0, RD_LATENCY);
    check("postrst_rdata", r0_rdata, 16'h6001);
    r0_req = 1'b0;
    step();

    // Address beyond the implemented rows.
    r1_we = 1'b1; r1_addr = 8'd12; r1_wdata = 16'hCCCC; r1_req = 1'b1;
    p0 = en_pulses;
    c0 = cyc;
    wait_ack(6, who);
    check("range_who", who, 1);
`ifdef MEM_ARB_RANGE_CHECK_EN
    check("range_latency", cyc - c0, RANGE_ERR_LATENCY);
    check("range_err", r1_err, 1);
    check("range_no_pulse", en_pulses - p0, 0);
    check("range_rdata_kept", r1_rdata, 16'hA5A5);
`else
    check("range_latency", cyc - c0, WR_LATENCY);
    check("range_err", r1_err, 0);
    check("range_pulse", en_pulses - p0, 1);
    check("range_address", memory_address, 12);
`endif
    r1_req = 1'b0;
    step();

    // Back-to-back writes from r0 with req held across transactions.
    a0 = r0_ack_cnt;
    last = 0;
    r0_we = 1'b1; r0_addr = 8'd0; r0_wdata = 16'hB000; r0_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(8, who);
      check("b2b_who", who, 0);
      if (k > 0) check("b2b_spacing", cyc - last, 3);
      last = cyc;
      if (k < 4) begin
        r0_addr  = 8'(k + 1);
        r0_wdata = 16'hB000 + 16'(k + 1);
      end else begin
        r0_req = 1'b0;
      end
    end
    step();
    check("b2b_ack_count", r0_ack_cnt - a0, 5);

    r1_we = 1'b0; r1_addr = 8'd2; r1_req = 1'b1;
    wait_ack(6, who);
    check("b2b_readback_who", who, 1);
    check("b2b_readback_data", r1_rdata, 16'hB002);
    r1_req = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
